// File: rtl/matmul_pkg.sv
// Shared sizing and FSM encoding for the result matrix store.
package matmul_pkg;
   localparam int DATA_W = 19;
   localparam int ADDR_W = 6;
   localparam int DEPTH  = 2 ** ADDR_W;
   localparam int CNT_W  = ADDR_W + 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FILL  = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_e;
endpackage

// File: rtl/result_ram.sv
// DEPTH x DATA_W element array: synchronous write, combinational read, no reset.
module result_ram
   import matmul_pkg::*;
(
   input  logic                     clk,
   input  logic                     we_i,
   input  logic [ADDR_W-1:0]        waddr_i,
   input  logic signed [DATA_W-1:0] wdata_i,
   input  logic [ADDR_W-1:0]        raddr_i,
   output logic signed [DATA_W-1:0] rdata_o
);
   logic signed [DATA_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/result_matrix_store.sv
// Collects an 8x8 result matrix in any address order, then drains it in ascending order
// over a valid/ready port.
module result_matrix_store
   import matmul_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     wr_valid,
   input  logic [ADDR_W-1:0]        wr_addr,
   input  logic signed [DATA_W-1:0] wr_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [ADDR_W-1:0]        out_addr,
   output logic signed [DATA_W-1:0] out_data,
   output logic                     full,
   output logic [CNT_W-1:0]         fill_count,
   output logic                     err_overrun
);
   state_e                   state_q, state_d;
   logic [DEPTH-1:0]         mask_q, mask_d;
   logic [CNT_W-1:0]         cnt_q, cnt_d;
   logic                     full_q, full_d;
   logic                     ov_q, ov_d;
   logic [ADDR_W-1:0]        oa_q, oa_d;
   logic signed [DATA_W-1:0] od_q, od_d;
   logic                     err_q, err_d;
   logic                     ram_we;
   logic [ADDR_W-1:0]        raddr;
   logic signed [DATA_W-1:0] rdata;

   result_ram u_ram (
      .clk     (clk),
      .we_i    (ram_we && !rst),
      .waddr_i (wr_addr),
      .wdata_i (wr_data),
      .raddr_i (raddr),
      .rdata_o (rdata)
   );

   // While draining, look one element ahead so the next word is ready at the handshake edge.
   assign raddr = (state_q == ST_DRAIN) ? oa_q + ADDR_W'(1) : '0;

   always_comb begin
      state_d = state_q;
      mask_d  = mask_q;
      cnt_d   = cnt_q;
      full_d  = full_q;
      ov_d    = ov_q;
      oa_d    = oa_q;
      od_d    = od_q;
      err_d   = err_q;
      ram_we  = 1'b0;
      if (start) begin
         state_d = ST_FILL;
         mask_d  = '0;
         cnt_d   = '0;
         full_d  = 1'b0;
         ov_d    = 1'b0;
         oa_d    = '0;
         od_d    = '0;
         err_d   = 1'b0;
      end else begin
         unique case (state_q)
            ST_FILL: begin
               if (wr_valid) begin
                  ram_we          = 1'b1;
                  mask_d[wr_addr] = 1'b1;
                  if (!mask_q[wr_addr]) begin
                     cnt_d = cnt_q + CNT_W'(1);
                     // Last distinct element lands on this edge; element 0 may be that very write.
                     if (cnt_q == CNT_W'(DEPTH - 1)) begin
                        state_d = ST_DRAIN;
                        full_d  = 1'b1;
                        ov_d    = 1'b1;
                        oa_d    = '0;
                        od_d    = (wr_addr == '0) ? wr_data : rdata;
                     end
                  end
               end
            end
            ST_DRAIN: begin
               if (wr_valid) err_d = 1'b1;
               if (ov_q && out_ready) begin
                  if (oa_q == ADDR_W'(DEPTH - 1)) begin
                     state_d = ST_DONE;
                     ov_d    = 1'b0;
                  end else begin
                     oa_d = oa_q + ADDR_W'(1);
                     od_d = rdata;
                  end
               end
            end
            default: begin
               if (wr_valid) err_d = 1'b1;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         mask_q  <= '0;
         cnt_q   <= '0;
         full_q  <= 1'b0;
         ov_q    <= 1'b0;
         oa_q    <= '0;
         od_q    <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         mask_q  <= mask_d;
         cnt_q   <= cnt_d;
         full_q  <= full_d;
         ov_q    <= ov_d;
         oa_q    <= oa_d;
         od_q    <= od_d;
         err_q   <= err_d;
      end
   end

   assign out_valid   = ov_q;
   assign out_addr    = oa_q;
   assign out_data    = od_q;
   assign full        = full_q;
   assign fill_count  = cnt_q;
   assign err_overrun = err_q;
endmodule

// File: tb/tb_result_matrix_store.sv
// Directed bench for result_matrix_store: fill/drain, duplicates, backpressure, overrun, reset abort.
module tb_result_matrix_store;
   import matmul_pkg::*;

   logic                     clk = 1'b0;
   logic                     rst, start, wr_valid, out_ready;
   logic [ADDR_W-1:0]        wr_addr;
   logic signed [DATA_W-1:0] wr_data;
   logic                     out_valid, full, err_overrun;
   logic [ADDR_W-1:0]        out_addr;
   logic signed [DATA_W-1:0] out_data;
   logic [CNT_W-1:0]         fill_count;

   int errs   = 0;
   int checks = 0;
   int em [DEPTH];

   result_matrix_store dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .wr_valid    (wr_valid),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_addr    (out_addr),
      .out_data    (out_data),
      .full        (full),
      .fill_count  (fill_count),
      .err_overrun (err_overrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic signed [63:0] act, input logic signed [63:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wr(input int a, input int d);
      wr_valid = 1'b1;
      wr_addr  = ADDR_W'(a);
      wr_data  = DATA_W'(d);
      em[a]    = d;
      tick();
      wr_valid = 1'b0;
   endtask

   // Drain all 64 elements, optionally throttling ready with a 1,0,0,1 pattern.
   task automatic drain(input bit toggle);
      bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      int idx = 0;
      int cyc = 0;
      bit hs;
      while (idx < DEPTH && cyc < 1000) begin
         out_ready = toggle ? pat[cyc % 4] : 1'b1;
         chk("drain_valid", out_valid, 1);
         if (out_valid !== 1'b1) break;
         chk("drain_addr", out_addr, idx);
         chk("drain_data", $signed(out_data), em[idx]);
         hs = out_valid && out_ready;
         tick();
         if (hs) idx++;
         cyc++;
      end
      out_ready = 1'b1;
      chk("drain_count", idx, DEPTH);
      chk("done_valid", out_valid, 0);
      chk("done_full", full, 1);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; wr_valid = 1'b0; out_ready = 1'b1;
      wr_addr = '0; wr_data = '0;
      tick(); tick();
      chk("rst_valid", out_valid, 0);
      chk("rst_full", full, 0);
      chk("rst_count", fill_count, 0);
      chk("rst_err", err_overrun, 0);
      chk("rst_addr", out_addr, 0);
      chk("rst_data", $signed(out_data), 0);
      rst = 1'b0;

      // Case 1: ascending fill, value = addr - 32
      pulse_start();
      for (int k = 0; k < DEPTH - 1; k++) wr(k, k - 32);
      chk("c1_count63", fill_count, 63);
      chk("c1_notfull", full, 0);
      chk("c1_fill_valid", out_valid, 0);
      wr(63, 31);
      chk("c1_full", full, 1);
      chk("c1_count64", fill_count, 64);
      drain(1'b0);

      // Case 4: write in DONE is dropped and flagged
      wr_valid = 1'b1; wr_addr = 6'd3; wr_data = 19'sd100;
      tick();
      wr_valid = 1'b0;
      chk("c4_err", err_overrun, 1);
      chk("c4_count", fill_count, 64);

      // Case 6: start with a same-cycle write
      start = 1'b1; wr_valid = 1'b1; wr_addr = 6'd3; wr_data = 19'sd100;
      tick();
      start = 1'b0; wr_valid = 1'b0;
      chk("c6_count", fill_count, 0);
      chk("c6_err", err_overrun, 0);
      chk("c6_full", full, 0);

      // Case 2: duplicate address 10, addr 63 last; Case 3 backpressure on drain
      wr(10, 7);
      chk("c2_count1", fill_count, 1);
      for (int k = 0; k < DEPTH - 1; k++) if (k != 10) wr(k, 3 * k - 100);
      wr(10, -7);
      chk("c2_count_dup", fill_count, 63);
      wr(63, 12345);
      chk("c2_count64", fill_count, 64);
      out_ready = 1'b0;
      wr_valid = 1'b1; wr_addr = 6'd0; wr_data = 19'sd5;
      tick();
      wr_valid = 1'b0;
      chk("c2_drain_err", err_overrun, 1);
      chk("c2_hold_addr", out_addr, 0);
      drain(1'b1);

      // Case 5: reset mid-fill aborts; writes ignored until a new start
      pulse_start();
      for (int k = 0; k < 20; k++) wr(k, k);
      chk("c5_count20", fill_count, 20);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("c5_valid", out_valid, 0);
      chk("c5_full", full, 0);
      chk("c5_count", fill_count, 0);
      chk("c5_err", err_overrun, 0);
      chk("c5_addr", out_addr, 0);
      chk("c5_data", $signed(out_data), 0);
      wr_valid = 1'b1; wr_addr = 6'd4; wr_data = 19'sd9;
      tick();
      wr_valid = 1'b0;
      chk("c5_idle_err", err_overrun, 1);
      chk("c5_idle_count", fill_count, 0);
      pulse_start();
      chk("c5_start_err", err_overrun, 0);
      for (int k = DEPTH - 1; k >= 0; k--) begin
         if (k == 0) wr(k, -262144);
         else if (k == DEPTH - 1) wr(k, 262143);
         else wr(k, k * 4099 - 131072);
      end
      chk("c5_full64", full, 1);
      drain(1'b0);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule

// File: doc/result_matrix_store.md
RESULT_MATRIX_STORE -- requirements
Module: result_matrix_store

Interface
REQ-001 DATA_W, 19, signed width of one result element; SHALL match the serializer's data width.
REQ-002 ADDR_W, 6, element address width; SHALL index an 8x8 matrix stored row-major.
REQ-003 DEPTH, 64, number of stored elements; SHALL equal 2**ADDR_W.
REQ-004 clk  in  1  single clock; all state SHALL change on its rising edge.
REQ-005 rst  in  1  reset; synchronous, active-high.
REQ-006 start  in  1  one-cycle pulse; SHALL clear the fill mask and begin a new fill.
REQ-007 wr_valid  in  1  SHALL qualify wr_addr/wr_data for one element write.
REQ-008 wr_addr  in  ADDR_W  SHALL carry the destination element index, taken from the serializer addr_out.
REQ-009 wr_data  in  DATA_W signed  SHALL carry the element value, taken from the serializer data_out.
REQ-010 out_valid  out  1  SHALL flag that out_addr/out_data hold a drained element.
REQ-011 out_ready  in  1  SHALL signal consumer acceptance.
REQ-012 out_addr  out  ADDR_W  SHALL carry the index of the element on out_data.
REQ-013 out_data  out  DATA_W signed  SHALL carry the drained element value.
REQ-014 full  out  1  SHALL be high while all 64 mask bits are set.
REQ-015 fill_count  out  7  SHALL count distinct written elements, 0..64.
REQ-016 err_overrun  out  1  SHALL be a sticky flag for writes dropped outside FILL.

Function
REQ-017 FSM states: IDLE, FILL, DRAIN, DONE; transitions SHALL be IDLE-start->FILL, FILL-(fill_count==64)->DRAIN, DRAIN-(handshake on addr 63)->DONE, DONE-start->FILL.
REQ-018 In FILL, wr_valid SHALL write mem[wr_addr] and set mask[wr_addr] in the same edge.
REQ-019 fill_count SHALL increment only when mask[wr_addr] was clear; a duplicate address SHALL overwrite data without incrementing.
REQ-020 FILL->DRAIN SHALL occur on the edge after the 64th distinct write, with full high from that edge.
REQ-021 First DRAIN cycle: out_valid=1, out_addr=0, out_data=mem[0]; elements SHALL follow in ascending address order.
REQ-022 Handshake = out_valid && out_ready; the next element SHALL be presented the cycle after the handshake, with no bubble; without a handshake, outputs SHALL hold stable.
REQ-023 out_valid SHALL be 0 in IDLE, FILL, DONE.
REQ-024 wr_valid in IDLE, DRAIN or DONE SHALL be ignored and SHALL set err_overrun.
REQ-025 start in any state SHALL clear mask, fill_count, full and out_valid and SHALL enter FILL; a same-cycle wr_valid SHALL be dropped without setting err_overrun.
REQ-026 err_overrun SHALL clear only on rst or start.
REQ-027 Stored data SHALL be kept bit-exact; there SHALL be no truncation or sign change.

Reset
REQ-028 rst SHALL force IDLE, mask=0, fill_count=0, full=0, out_valid=0, out_addr=0, out_data=0, err_overrun=0; rst SHALL take priority over start and wr_valid.
REQ-029 Memory contents SHALL not be reset; they SHALL be undefined until written.
REQ-030 rst asserted mid-FILL or mid-DRAIN SHALL abort the operation; the next element SHALL be accepted only after a new start.

Structure
REQ-031 Package matmul_pkg SHALL hold DATA_W, ADDR_W, DEPTH and the FSM state encoding.
REQ-032 One sub-module, result_ram, SHALL implement the DEPTH x DATA_W array with synchronous write and combinational read.
REQ-033 The FSM, mask, counters and output registers SHALL reside in result_matrix_store.

Verification
REQ-034 Case 1: rst, start, then 64 writes with addr k = value k-32, out_ready=1 -> full is set after the 64th write; 64 outputs follow in order, with addr 5 giving -27; the block ends in DONE.
REQ-035 Case 2: 64 writes with addr 10 written twice (7 then -7), plus addr 63 written last -> fill_count stays 64; addr 10 drains as -7.
REQ-036 Case 3: during DRAIN, out_ready is toggled 1,0,0,1 -> out_addr/out_data hold while low; no element is skipped or duplicated.
REQ-037 Case 4: wr_valid with addr 3, data 100 in DONE -> err_overrun=1; mem[3] is unchanged; a later start clears err_overrun.
REQ-038 Case 5: rst after 20 writes -> all outputs return to reset values; start followed by 64 writes then completes normally.
REQ-039 Case 6: start and wr_valid in the same cycle -> fill_count=0 and err_overrun=0 on the next cycle.
